// File: rtl/mam_arb_pkg.sv
// Shared state encoding, beat-counter width and index helper for the MAM port arbiter.
package mam_arb_pkg;

   localparam int unsigned BEATS_WIDTH = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2,
      READ  = 2'd3
   } arb_state_e;

   // Index of the set bit in a one-hot vector of up to eight requesters.
   function automatic logic [2:0] onehot2idx(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (onehot[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mam_rr_arbiter.sv
// Combinational rotating-priority picker: first requester at or after ptr wins, wrapping at PORTS.
module mam_rr_arbiter #(
   parameter  int unsigned PORTS = 2,
   localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic [PORTS-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [PORTS-1:0] grant
);

   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned off = 0; off < PORTS; off++) begin
         for (int unsigned i = 0; i < PORTS; i++) begin
            if (!found && req[i] && (i == (32'(ptr) + off) % PORTS)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mam_port_arbiter.sv
// Shares one MAM memory port between PORTS requesters, holding the grant for a whole transaction.
// Build option MAM_ARB_FIXED_PRIO_EN: lowest-index requester always wins and the pointer is dropped.
module mam_port_arbiter
   import mam_arb_pkg::*;
#(
   parameter int unsigned PORTS      = 2,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS-1:0]              in_req_valid,
   output logic [PORTS-1:0]              in_req_ready,
   input  logic [PORTS-1:0]              in_req_rw,
   input  logic [PORTS*ADDR_WIDTH-1:0]   in_req_addr,
   input  logic [PORTS-1:0]              in_req_burst,
   input  logic [PORTS*BEATS_WIDTH-1:0]  in_req_beats,
   input  logic [PORTS-1:0]              in_write_valid,
   input  logic [PORTS*DATA_WIDTH-1:0]   in_write_data,
   input  logic [PORTS*DATA_WIDTH/8-1:0] in_write_strb,
   output logic [PORTS-1:0]              in_write_ready,
   output logic [PORTS-1:0]              in_read_valid,
   output logic [DATA_WIDTH-1:0]         in_read_data,
   input  logic [PORTS-1:0]              in_read_ready,
   output logic                          out_req_valid,
   output logic                          out_req_rw,
   output logic [ADDR_WIDTH-1:0]         out_req_addr,
   output logic                          out_req_burst,
   output logic [BEATS_WIDTH-1:0]        out_req_beats,
   input  logic                          out_req_ready,
   output logic                          out_write_valid,
   output logic [DATA_WIDTH-1:0]         out_write_data,
   output logic [DATA_WIDTH/8-1:0]       out_write_strb,
   input  logic                          out_write_ready,
   input  logic                          out_read_valid,
   input  logic [DATA_WIDTH-1:0]         out_read_data,
   output logic                          out_read_ready,
   output logic [PORTS-1:0]              grant
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = (PORTS > 1) ? $clog2(PORTS) : 1;

   arb_state_e             state_q, state_d;
   logic [PORTS-1:0]       grant_q, grant_d, arb_grant;
   logic [IDX_W-1:0]       ptr_q;
   logic [BEATS_WIDTH-1:0] cnt_q, cnt_d;

   logic                   sel_req_valid, sel_rw, sel_burst, sel_wvalid, sel_rready;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [BEATS_WIDTH-1:0] sel_beats;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   logic [STRB_W-1:0]      sel_wstrb;

   mam_rr_arbiter #(.PORTS(PORTS)) u_arb (
      .req   (in_req_valid),
      .ptr   (ptr_q),
      .grant (arb_grant)
   );

   // Slice of the current owner; all zero while nobody holds the grant.
   always_comb begin
      sel_req_valid = 1'b0;
      sel_rw        = 1'b0;
      sel_burst     = 1'b0;
      sel_wvalid    = 1'b0;
      sel_rready    = 1'b0;
      sel_addr      = '0;
      sel_beats     = '0;
      sel_wdata     = '0;
      sel_wstrb     = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         if (grant_q[i]) begin
            sel_req_valid = in_req_valid[i];
            sel_rw        = in_req_rw[i];
            sel_burst     = in_req_burst[i];
            sel_wvalid    = in_write_valid[i];
            sel_rready    = in_read_ready[i];
            sel_addr      = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_beats     = in_req_beats[i*BEATS_WIDTH +: BEATS_WIDTH];
            sel_wdata     = in_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_wstrb     = in_write_strb[i*STRB_W +: STRB_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state plus handshake routing between the owner and the memory port.
   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      cnt_d           = cnt_q;
      in_req_ready    = '0;
      in_write_ready  = '0;
      in_read_valid   = '0;
      out_req_valid   = 1'b0;
      out_req_rw      = 1'b0;
      out_req_addr    = '0;
      out_req_burst   = 1'b0;
      out_req_beats   = '0;
      out_write_valid = 1'b0;
      out_write_data  = '0;
      out_write_strb  = '0;
      out_read_ready  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|arb_grant) begin
               grant_d = arb_grant;
               state_d = REQ;
            end
         end
         REQ: begin
            out_req_valid = sel_req_valid;
            out_req_rw    = sel_rw;
            out_req_addr  = sel_addr;
            out_req_burst = sel_burst;
            out_req_beats = sel_beats;
            in_req_ready  = grant_q & {PORTS{out_req_ready}};
            if (sel_req_valid && out_req_ready) begin
               if (sel_burst && (sel_beats == '0)) begin
                  state_d = IDLE;
                  grant_d = '0;
               end else begin
                  cnt_d   = sel_burst ? sel_beats : BEATS_WIDTH'(1);
                  state_d = sel_rw ? WRITE : READ;
               end
            end
         end
         WRITE: begin
            out_write_valid = sel_wvalid;
            out_write_data  = sel_wdata;
            out_write_strb  = sel_wstrb;
            in_write_ready  = grant_q & {PORTS{out_write_ready}};
            if (sel_wvalid && out_write_ready) begin
               cnt_d = cnt_q - BEATS_WIDTH'(1);
               if (cnt_q == BEATS_WIDTH'(1)) begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         READ: begin
            in_read_valid  = grant_q & {PORTS{out_read_valid}};
            out_read_ready = sel_rready;
            if (out_read_valid && sel_rready) begin
               cnt_d = cnt_q - BEATS_WIDTH'(1);
               if (cnt_q == BEATS_WIDTH'(1)) begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

`ifdef MAM_ARB_FIXED_PRIO_EN
   assign ptr_q = '0;
`else
   logic [IDX_W-1:0] g_idx;

   always_comb g_idx = IDX_W'(onehot2idx(8'(grant_q)));

   // Every completed transaction hands priority to the next requester after the owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if ((state_q != IDLE) && (state_d == IDLE)) begin
         ptr_q <= (g_idx == IDX_W'(PORTS - 1)) ? '0 : g_idx + IDX_W'(1);
      end
   end
`endif

   assign in_read_data = out_read_data;
   assign grant        = grant_q;

endmodule

// File: tb/tb_mam_port_arbiter.sv
// Directed bench for mam_port_arbiter (2 ports, 16-bit data, 32-bit address).
module tb_mam_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned BW = 14;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_req_valid, in_req_ready, in_req_rw, in_req_burst;
   logic [63:0] in_req_addr;
   logic [27:0] in_req_beats;
   logic [1:0]  in_write_valid, in_write_ready;
   logic [31:0] in_write_data;
   logic [3:0]  in_write_strb;
   logic [1:0]  in_read_valid, in_read_ready;
   logic [15:0] in_read_data;
   logic        out_req_valid, out_req_rw, out_req_burst, out_req_ready;
   logic [31:0] out_req_addr;
   logic [13:0] out_req_beats;
   logic        out_write_valid, out_write_ready;
   logic [15:0] out_write_data;
   logic [1:0]  out_write_strb;
   logic        out_read_valid, out_read_ready;
   logic [15:0] out_read_data;
   logic [1:0]  grant;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mam_port_arbiter #(.PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
      .in_req_addr(in_req_addr), .in_req_burst(in_req_burst), .in_req_beats(in_req_beats),
      .in_write_valid(in_write_valid), .in_write_data(in_write_data),
      .in_write_strb(in_write_strb), .in_write_ready(in_write_ready),
      .in_read_valid(in_read_valid), .in_read_data(in_read_data), .in_read_ready(in_read_ready),
      .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
      .out_req_burst(out_req_burst), .out_req_beats(out_req_beats), .out_req_ready(out_req_ready),
      .out_write_valid(out_write_valid), .out_write_data(out_write_data),
      .out_write_strb(out_write_strb), .out_write_ready(out_write_ready),
      .out_read_valid(out_read_valid), .out_read_data(out_read_data),
      .out_read_ready(out_read_ready), .grant(grant)
   );

   // A granted requester must hold in_req_valid until its request is accepted.
   logic [1:0] hs_done;
   always @(posedge clk) begin
      if (rst) hs_done <= 2'b00;
      else     hs_done <= (hs_done | (in_req_valid & in_req_ready)) & grant;
   end
   always @(negedge clk) begin
      if (!rst)
         assert (!(|(grant & ~in_req_valid & ~hs_done)))
            else $error("requester retracted an unacknowledged request, grant=%b", grant);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int p, input logic rw, input logic burst,
                          input logic [13:0] beats, input logic [31:0] addr);
      in_req_valid = in_req_valid | (2'b01 << p);
      in_req_rw    = (in_req_rw & ~(2'b01 << p)) | (2'(rw) << p);
      in_req_burst = (in_req_burst & ~(2'b01 << p)) | (2'(burst) << p);
      in_req_beats[p*BW +: BW] = beats;
      in_req_addr[p*AW +: AW]  = addr;
   endtask

   task automatic clr_req(input int p);
      in_req_valid = in_req_valid & ~(2'b01 << p);
   endtask

   // Waits (bounded) for a grant, then compares it; returns at the negedge of the REQ cycle.
   task automatic wait_grant(input string tag, input logic [1:0] exp);
      int n;
      n = 0;
      @(negedge clk);
      while (grant == 2'b00 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(grant), 32'(exp));
   endtask

   // Request handshake with out_req_ready held high; drops the request right after.
   task automatic req_hs(input int p, input string tag);
      check({tag, "_rdy"}, 32'(in_req_ready), 32'(2'b01 << p));
      tick();
      clr_req(p);
   endtask

   task automatic read_beat(input int p, input logic [15:0] d, input string tag);
      out_read_valid = 1'b1;
      out_read_data  = d;
      in_read_ready  = 2'b11;
      @(negedge clk);
      check({tag, "_vld"}, 32'(in_read_valid), 32'(2'b01 << p));
      check({tag, "_data"}, 32'(in_read_data), 32'(d));
      check({tag, "_rdy"}, 32'(out_read_ready), 32'(1));
      tick();
      out_read_valid = 1'b0;
      in_read_ready  = 2'b00;
   endtask

   initial begin
      int n;
      int k;
      logic leak;
      logic [7:0] seq;

      rst = 1'b1;
      in_req_valid = '0; in_req_rw = '0; in_req_burst = '0; in_req_addr = '0; in_req_beats = '0;
      in_write_valid = '0; in_write_data = '0; in_write_strb = '0; in_read_ready = '0;
      out_req_ready = 1'b1; out_write_ready = 1'b1;
      out_read_valid = 1'b0; out_read_data = '0;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_req_valid", 32'(out_req_valid), 32'(0));
      check("rst_req_ready", 32'(in_req_ready), 32'(0));
      check("rst_wr", 32'({out_write_valid, in_write_ready}), 32'(0));
      check("rst_rd", 32'({out_read_ready, in_read_valid}), 32'(0));
      tick();

      // Single write burst of 3 on port 0
      set_req(0, 1'b1, 1'b1, 14'd3, 32'h100);
      in_write_valid = 2'b01;
      in_write_strb  = 4'b0011;
      in_write_data[15:0] = 16'hA000;
      @(negedge clk);
      check("wr_lat_grant", 32'(grant), 32'(0));
      check("wr_lat_valid", 32'(out_req_valid), 32'(0));
      wait_grant("wr_grant", 2'b01);
      check("wr_addr", out_req_addr, 32'h100);
      check("wr_beats", 32'(out_req_beats), 32'(3));
      check("wr_rw", 32'(out_req_rw), 32'(1));
      req_hs(0, "wr");
      n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_write_valid && out_write_ready) begin
            check("wr_data", 32'(out_write_data), 32'(16'hA000 + n));
            check("wr_wready", 32'(in_write_ready), 32'(2'b01));
            check("wr_strb", 32'(out_write_strb), 32'(2'b11));
            n++;
         end
         tick();
         in_write_data[15:0] = 16'(16'hA000 + n);
      end
      check("wr_beat_count", 32'(n), 32'(3));
      in_write_valid = 2'b00;
      @(negedge clk);
      check("wr_idle", 32'(grant), 32'(0));
      tick();

      // Contention: single reads on both ports, pointer at 0
      do_reset();
      set_req(0, 1'b0, 1'b0, 14'd0, 32'h1000);
      set_req(1, 1'b0, 1'b0, 14'd0, 32'h2000);
      wait_grant("ct_grant0", 2'b01);
      check("ct_addr0", out_req_addr, 32'h1000);
      req_hs(0, "ct0");
      read_beat(0, 16'h1111, "ct_rd0");
      @(negedge clk);
      check("ct_gap", 32'(grant), 32'(0));
      wait_grant("ct_grant1", 2'b10);
      check("ct_addr1", out_req_addr, 32'h2000);
      req_hs(1, "ct1");
      read_beat(1, 16'h2222, "ct_rd1");

      // Read burst of 4 with random backpressure on both sides
      set_req(0, 1'b0, 1'b1, 14'd4, 32'h3000);
      wait_grant("bp_grant", 2'b01);
      req_hs(0, "bp");
      n = 0;
      leak = 1'b0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         out_read_valid = 1'($urandom_range(0, 1));
         out_read_data  = 16'(16'hB000 + n);
         in_read_ready  = {1'b1, 1'($urandom_range(0, 1))};
         @(negedge clk);
         if (in_read_valid[1]) leak = 1'b1;
         if (in_read_valid[0] && in_read_ready[0]) begin
            check("bp_data", 32'(in_read_data), 32'(16'hB000 + n));
            n++;
         end
         tick();
      end
      out_read_valid = 1'b0;
      in_read_ready  = 2'b00;
      check("bp_count", 32'(n), 32'(4));
      check("bp_leak", 32'(leak), 32'(0));
      @(negedge clk);
      check("bp_idle", 32'(grant), 32'(0));
      tick();

      // Zero-length burst on port 1, then the pointer must favour port 0
      set_req(1, 1'b1, 1'b1, 14'd0, 32'h4000);
      wait_grant("zl_grant", 2'b10);
      check("zl_valid", 32'(out_req_valid), 32'(1));
      check("zl_beats", 32'(out_req_beats), 32'(0));
      req_hs(1, "zl");
      in_write_valid = 2'b10;
      @(negedge clk);
      check("zl_idle", 32'(grant), 32'(0));
      check("zl_nowrite", 32'({out_write_valid, in_write_ready}), 32'(0));
      tick();
      in_write_valid = 2'b00;
      set_req(0, 1'b0, 1'b0, 14'd0, 32'h5000);
      set_req(1, 1'b0, 1'b0, 14'd0, 32'h6000);
      wait_grant("zl_ptr", 2'b01);
      req_hs(0, "pa");
      clr_req(1);
      read_beat(0, 16'h5555, "pa_rd");

      // Reset during beat 2 of a 5-beat write on port 1
      set_req(1, 1'b1, 1'b1, 14'd5, 32'h7000);
      in_write_valid = 2'b10;
      in_write_data[31:16] = 16'hC000;
      wait_grant("ab_grant", 2'b10);
      req_hs(1, "ab");
      @(negedge clk);
      check("ab_beat1", 32'(out_write_valid), 32'(1));
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("ab_beat2", 32'(out_write_valid), 32'(1));
      tick();
      rst = 1'b0;
      in_write_valid = 2'b00;
      @(negedge clk);
      check("ab_grant0", 32'(grant), 32'(0));
      check("ab_outs", 32'({out_write_valid, in_write_ready, out_req_valid, in_req_ready,
                            out_read_ready, in_read_valid}), 32'(0));
      tick();
      set_req(0, 1'b1, 1'b1, 14'd0, 32'h8000);
      set_req(1, 1'b1, 1'b0, 14'd7, 32'h9000);
      wait_grant("rs_ptr", 2'b01);
      req_hs(0, "rs0");
      @(negedge clk);
      check("rs_gap", 32'(grant), 32'(0));
      wait_grant("rs_grant1", 2'b10);
      check("rs_addr", out_req_addr, 32'h9000);
      check("rs_burst", 32'(out_req_burst), 32'(0));
      req_hs(1, "rs1");
      in_write_valid = 2'b10;
      in_write_data[31:16] = 16'hD000;
      n = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_write_valid && out_write_ready) begin
            check("rs_data", 32'(out_write_data), 32'(16'hD000));
            n++;
         end
         tick();
      end
      check("rs_count", 32'(n), 32'(1));
      in_write_valid = 2'b00;

      // Both ports requesting continuously: arbitration order over four transactions
      do_reset();
      out_read_valid = 1'b1;
      out_read_data  = 16'h7777;
      in_read_ready  = 2'b11;
      set_req(0, 1'b0, 1'b0, 14'd0, 32'hA0);
      set_req(1, 1'b0, 1'b0, 14'd0, 32'hB0);
      k = 0;
      seq = '0;
      for (int c = 0; c < 20 && k < 4; c++) begin
         @(negedge clk);
         if (out_req_valid && out_req_ready) begin
            seq = {seq[5:0], grant};
            k++;
         end
         tick();
      end
      clr_req(0);
      clr_req(1);
      tick();
      out_read_valid = 1'b0;
      in_read_ready  = 2'b00;
`ifdef MAM_ARB_FIXED_PRIO_EN
      check("prio_seq", 32'(seq), 32'(8'b01_01_01_01));
`else
      check("rr_seq", 32'(seq), 32'(8'b01_10_01_10));
`endif
      @(negedge clk);
      check("seq_idle", 32'(grant), 32'(0));
      tick();

      // Maximum burst length must run to completion without an early wrap
      set_req(0, 1'b1, 1'b1, 14'h3FFF, 32'hC00);
      in_write_valid = 2'b01;
      wait_grant("big_grant", 2'b01);
      check("big_beats", 32'(out_req_beats), 32'h3FFF);
      req_hs(0, "big");
      n = 0;
      for (int c = 0; c < 16400; c++) begin
         @(negedge clk);
         if (grant == 2'b00) break;
         if (out_write_valid && out_write_ready) n++;
         tick();
      end
      check("big_count", 32'(n), 32'h3FFF);
      in_write_valid = 2'b00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
